uart_rx: RTL

- 16x-oversampled UART receiver; the receive end of the team's UART link.
- Pairs with the existing transmitter: same shared baud_tick source, same 8N1 framing, LSB first.
- Recovers serial frames from the asynchronous rx line and presents each byte with a one-cycle done strobe.
- Reports stop-bit (framing) errors and rejects glitch-induced false starts.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART link definitions: receiver FSM states and oversampling constants.
// The transmitter uses these as well.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_START  = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'd15;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a selectable reset value.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver, LSB first.
// Emits a one-cycle rx_done per good frame, frame_err per bad stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int data_bits  = 8,
  parameter int oversample = OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [data_bits-1:0] data_out,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(oversample);
  localparam int BW = $clog2(data_bits);

  localparam logic [TW-1:0] MID      = TW'(MID_START);
  localparam logic [TW-1:0] LAST     = TW'(LAST_TICK);
  localparam logic [BW-1:0] LAST_BIT = BW'(data_bits - 1);

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [data_bits-1:0] shift_q, shift_d;
  logic [data_bits-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_s;
  logic                 rx_prev_q;

  // Reset value 1 keeps reset release from looking like a start edge.
  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      rx_prev_q <= rx_s;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          tick_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          if (tick_q == MID) begin
            if (!rx_s) begin
              tick_d  = '0;
              bit_d   = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (tick_q == LAST) begin
            shift_d = {rx_s, shift_q[data_bits-1:1]};
            tick_d  = '0;
            if (bit_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (tick_q == LAST) begin
            // Back to IDLE at mid stop so a following start edge is caught.
            if (rx_s) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out  = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule
